// File: rtl/boot_sequencer_if.sv
// Image stream and instruction-memory write bundle for boot_sequencer.
// slave = sequencer side, master = image source / memory side.
interface boot_sequencer_if;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_sequencer.sv
// Core boot sequencer: reset hold, optional image preload, release, halt/restart.
// Define BOOT_CHECKSUM_EN to treat the last stream word as a checksum trailer.
module boot_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter bit          PRELOAD       = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] bootPC,
    input  logic        halt,
    input  logic        restart,
    output logic        proc_RESET,
    output logic [31:0] startPC,
    output logic        booted,
    output logic        error,
    output logic [10:0] word_count,
    boot_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_e;

    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [10:0] MAXW        = 11'(MAX_WORDS);

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [31:0] startpc_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        prst_q;
    logic        booted_q;
    logic        error_q;
    logic [10:0] wc_q;

    logic        room;
    logic        accept;
    logic [31:0] addr_d;

    assign room           = wc_q < MAXW;
    assign bus.load_ready = (state_q == S_LOAD) && room;
    assign accept         = bus.load_valid && bus.load_ready;
    assign addr_d         = startpc_q + {19'd0, wc_q, 2'b00};

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        sum_ok;
    assign sum_ok = (sum_q == bus.load_data);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            startpc_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            prst_q    <= 1'b1;
            booted_q  <= 1'b0;
            error_q   <= 1'b0;
            wc_q      <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                S_HOLD: begin
`ifdef BOOT_CHECKSUM_EN
                    sum_q <= '0;
`endif
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        startpc_q <= bootPC;
                        addr_q    <= bootPC;
                        state_q   <= PRELOAD ? S_LOAD : S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                        // Trailer word is only compared, never written or counted
                        if (bus.load_last) begin
                            if (sum_ok) begin
                                state_q <= S_SETTLE;
                            end else begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end
                        end else begin
                            we_q    <= 1'b1;
                            wdata_q <= bus.load_data;
                            addr_q  <= addr_d;
                            wc_q    <= wc_q + 11'd1;
                            sum_q   <= sum_q + bus.load_data;
                        end
`else
                        we_q    <= 1'b1;
                        wdata_q <= bus.load_data;
                        addr_q  <= addr_d;
                        wc_q    <= wc_q + 11'd1;
                        if (bus.load_last) begin
                            state_q <= S_SETTLE;
                        end
`endif
                    end else if (bus.load_valid && !room) begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                        prst_q   <= 1'b0;
                        booted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state_q  <= S_HALTED;
                        prst_q   <= 1'b1;
                        booted_q <= 1'b0;
                    end
                end
                S_HALTED: begin
                    if (restart) begin
                        state_q <= S_HOLD;
                        wc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_ERROR: begin
                    if (restart) begin
                        state_q <= S_HOLD;
                        error_q <= 1'b0;
                        wc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    assign proc_RESET     = prst_q;
    assign startPC        = startpc_q;
    assign booted         = booted_q;
    assign error          = error_q;
    assign word_count     = wc_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed-plus-random bench for boot_sequencer against a queue-based write model.
// Build with BOOT_CHECKSUM_EN defined to exercise the trailer checksum.
module tb_boot_sequencer;

    localparam int H  = 5;
    localparam int S  = 4;
    localparam int MW = 4;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] bootPC = '0;
    logic        halt = 1'b0;
    logic        restart = 1'b0;
    logic        proc_RESET;
    logic [31:0] startPC;
    logic        booted;
    logic        error;
    logic [10:0] word_count;

    boot_sequencer_if bus();

    boot_sequencer #(
        .HOLD_CYCLES  (H),
        .SETTLE_CYCLES(S),
        .MAX_WORDS    (MW),
        .PRELOAD      (1'b1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .bootPC    (bootPC),
        .halt      (halt),
        .restart   (restart),
        .proc_RESET(proc_RESET),
        .startPC   (startPC),
        .booted    (booted),
        .error     (error),
        .word_count(word_count),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0] oa[$];
    logic [31:0] od[$];
    int          oc[$];
    int          ac[$];
    logic [31:0] wq[$];
    bit          gp[$];
    int          last_acc;
    int          passed = 0;
    int          fails = 0;
    int          total = 0;

    always @(negedge CLK) begin
        if (bus.imem_we === 1'b1) begin
            oa.push_back(bus.imem_addr);
            od.push_back(bus.imem_wdata);
            oc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_prst"},  32'(proc_RESET), 32'd1);
        chk({tag, "_spc"},   startPC, 32'd0);
        chk({tag, "_rdy"},   32'(bus.load_ready), 32'd0);
        chk({tag, "_we"},    32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"},  bus.imem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_boot"},  32'(booted), 32'd0);
        chk({tag, "_err"},   32'(error), 32'd0);
        chk({tag, "_wc"},    32'(word_count), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        bit bad = 1'b0;
        while (bus.load_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
            if (proc_RESET !== 1'b1 && bus.load_ready !== 1'b1) bad = 1'b1;
        end
        chk({tag, "_hold_len"}, 32'(n), 32'(H));
        chk({tag, "_hold_prst"}, 32'(bad), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge CLK);
        restart = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        @(negedge CLK);
        halt = 1'b0;
    endtask

    task automatic send(input bit last_final, input bit trl);
        int  idx = 0;
        int  guard = 0;
        bit  v;
        oa.delete(); od.delete(); oc.delete(); ac.delete();
        while (idx < wq.size() && guard < 300) begin
            v = (gp.size() > 0) ? gp.pop_front() : ($urandom_range(0, 2) != 0);
            bus.load_valid = v;
            bus.load_data  = v ? wq[idx] : $urandom;
            bus.load_last  = v ? (last_final && idx == wq.size() - 1)
                               : 1'($urandom_range(0, 1));
            if (v && bus.load_ready === 1'b1) begin
                last_acc = cyc;
                if (!(trl && idx == wq.size() - 1)) ac.push_back(cyc);
                idx++;
            end
            @(negedge CLK);
            guard++;
            if (error === 1'b1) break;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("send_bound", 32'(guard < 300), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] base,
                                input int n);
        logic [31:0] ea;
        chk({tag, "_nwr"}, 32'(oa.size()), 32'(n));
        for (int i = 0; i < n && i < oa.size() && i < ac.size(); i++) begin
            ea = base + 32'(4 * i);
            chk({tag, "_waddr"}, oa[i], ea);
            chk({tag, "_wdata"}, od[i], wq[i]);
            chk({tag, "_wcyc"}, 32'(oc[i]), 32'(ac[i] + 1));
        end
    endtask

    task automatic wait_run(input string tag, input logic [31:0] pc,
                            input int n);
        int g = 0;
        while (proc_RESET !== 1'b0 && g < 100) begin
            @(negedge CLK);
            g++;
        end
        chk({tag, "_rel_cyc"}, 32'(cyc), 32'(last_acc + 1 + S));
        chk({tag, "_booted"}, 32'(booted), 32'd1);
        chk({tag, "_spc"}, startPC, pc);
        chk({tag, "_wc"}, 32'(word_count), 32'(n));
        chk({tag, "_err"}, 32'(error), 32'd0);
    endtask

    task automatic fill(input int n, input bit trailer, input bit bad);
        logic [31:0] sum = '0;
        wq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back($urandom);
            sum = sum + wq[i];
        end
        if (trailer) wq.push_back(bad ? sum + 32'd1 : sum);
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] prev;
        int          n;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bootPC = 32'h100;

        repeat (3) @(negedge CLK);
        reset_check("rst");
        RESET = 1'b0;
        wait_ready("b0");
        chk("b0_spc_latch", startPC, 32'h100);
        chk("b0_addr_latch", bus.imem_addr, 32'h100);

        wq = '{32'hA0, 32'hA1, 32'hA2};
        if (CK) wq.push_back(32'h1E3);
        gp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        send(1'b1, CK);
        wait_run("b0", 32'h100, 3);
        check_writes("b0", 32'h100, 3);

        pulse_restart();
        @(negedge CLK);
        chk("run_rst_ign_boot", 32'(booted), 32'd1);
        chk("run_rst_ign_prst", 32'(proc_RESET), 32'd0);
        pulse_halt();
        chk("halt_prst", 32'(proc_RESET), 32'd1);
        chk("halt_boot", 32'(booted), 32'd0);

        prev = 32'h100;
        for (int k = 0; k < 3; k++) begin
            pc = (k == 0) ? 32'h200 : (k == 1) ? 32'hFFFF_FFF8
                                               : ($urandom & 32'hFFFF_FFFC);
            bootPC = pc;
            @(negedge CLK);
            chk("halted_spc_hold", startPC, prev);
            pulse_restart();
            wait_ready("rb");
            chk("rb_spc_latch", startPC, pc);
            n = $urandom_range(1, MW);
            fill(n, CK, 1'b0);
            send(1'b1, CK);
            wait_run("rb", pc, n);
            check_writes("rb", pc, n);
            pulse_halt();
            prev = pc;
        end

        pulse_restart();
        wait_ready("ov");
        fill(MW + 1, 1'b0, 1'b0);
        send(1'b0, 1'b0);
        @(negedge CLK);
        chk("ov_err", 32'(error), 32'd1);
        chk("ov_prst", 32'(proc_RESET), 32'd1);
        chk("ov_boot", 32'(booted), 32'd0);
        chk("ov_wc", 32'(word_count), 32'(MW));
        chk("ov_rdy", 32'(bus.load_ready), 32'd0);
        check_writes("ov", prev, MW);
        pulse_halt();
        chk("ov_halt_ign", 32'(error), 32'd1);
        pulse_restart();
        chk("ov_clr_err", 32'(error), 32'd0);
        wait_ready("ov2");
        n = $urandom_range(1, MW);
        fill(n, CK, 1'b0);
        send(1'b1, CK);
        wait_run("ov2", prev, n);
        check_writes("ov2", prev, n);
        pulse_halt();

`ifdef BOOT_CHECKSUM_EN
        pulse_restart();
        wait_ready("ck");
        n = 3;
        fill(n, 1'b1, 1'b1);
        send(1'b1, 1'b1);
        @(negedge CLK);
        chk("ck_err", 32'(error), 32'd1);
        chk("ck_prst", 32'(proc_RESET), 32'd1);
        chk("ck_wc", 32'(word_count), 32'(n));
        check_writes("ck", prev, n);
`endif

        pulse_restart();
        wait_ready("mr");
        oa.delete(); od.delete(); oc.delete();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h5A5A_0001;
        bus.load_last  = 1'b0;
        @(negedge CLK);
        bus.load_data  = 32'h5A5A_0002;
        #2 RESET = 1'b1;
        #1 reset_check("mr");
        chk("mr_one_write", 32'(oa.size()), 32'd1);
        repeat (2) @(negedge CLK);
        chk("mr_no_more_we", 32'(oa.size()), 32'd1);
        bus.load_valid = 1'b0;
        RESET = 1'b0;
        wait_ready("mr2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, %0d/%0d checks", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sits directly upstream of the processor core and replaces the static stimulus driver that ties its reset and start address.
- Generates the core's reset pulse and start address (startPC).
- Optionally streams a program image into instruction memory before the core starts.
- Releases the core, watches for halt, and supports warm restart.

Parameters:
HOLD_CYCLES, 16, cycles the core reset is held after system reset or restart (>=1)
SETTLE_CYCLES, 4, cycles between last image write and core reset release (>=1)
MAX_WORDS, 1024, maximum image length in 32-bit words
PRELOAD, 1, 1 = load an image before release; 0 = skip the LOAD state

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high system reset
bootPC  input  32  image base and start address; sampled on HOLD exit
load_valid  input  1  image stream word valid
load_data  input  32  image stream word
load_last  input  1  marks final image word
load_ready  output  1  sequencer accepts a stream word
imem_we  output  1  instruction memory write strobe
imem_addr  output  32  instruction memory byte address
imem_wdata  output  32  instruction memory write data
proc_RESET  output  1  core reset, active-high
startPC  output  32  core start address
halt  input  1  core has halted (level)
restart  input  1  one-cycle pulse to re-boot from HALTED or ERROR
booted  output  1  core is running
error  output  1  boot failure flag
word_count  output  11  words written in the current load

Behaviour:
- States: HOLD, LOAD, SETTLE, RUN, HALTED, ERROR.
- Async RESET forces HOLD with these values:
  - proc_RESET=1, startPC=0, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - booted=0, error=0, word_count=0, internal counter=0.
- Reset asserted mid-operation aborts any state immediately. No partial write completes after reset asserts.
- HOLD: counter increments each cycle. At count HOLD_CYCLES-1:
  - startPC <= bootPC.
  - imem_addr <= bootPC.
  - counter clears.
  - Next state is LOAD if PRELOAD=1, else SETTLE.
- LOAD: load_ready=1 combinationally while in LOAD and word_count < MAX_WORDS. A beat is accepted when load_valid && load_ready. On acceptance:
  - imem_we=1 on the following cycle (registered, one-cycle latency).
  - imem_wdata=load_data.
  - imem_addr = startPC + 4*word_count, using the pre-increment count.
  - word_count increments.
  - Address arithmetic is 32-bit modulo 2^32, so wrap past 0xFFFFFFFC is permitted.
- LOAD exit conditions:
  - Accepted beat with load_last=1: go to SETTLE.
  - Valid beat offered while word_count==MAX_WORDS: go to ERROR and set error=1. The beat is not written.
  - load_valid low: stall indefinitely with no timeout.
- imem_we is low in every state other than the cycle after an accepted beat.
- SETTLE: proc_RESET=1. The counter runs for SETTLE_CYCLES, then go to RUN.
- RUN: proc_RESET=0, booted=1. If halt=1, go to HALTED on the next edge.
- HALTED: proc_RESET=1, booted=0. restart=1 goes to HOLD, clearing word_count and the counter.
- ERROR: proc_RESET=1, error=1. restart=1 goes to HOLD and clears error.
- restart is ignored in HOLD, LOAD, SETTLE and RUN.
- halt is ignored outside RUN.
- startPC holds its value from HOLD exit until the next HOLD exit.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit running sum (modulo 2^32) accumulates every accepted non-last word.
  - The load_last word is a trailer compared against that sum and is not written to memory.
  - On match, go to SETTLE.
  - On mismatch, go to ERROR with error=1.
  - word_count excludes the trailer.
  - The sum clears on HOLD.
- Without the macro, the last word is ordinary image data and is written; no sum logic exists.

Test Plan:
- Plain boot, PRELOAD=1, no checksum:
  - Stimulus: RESET high 3 cycles then low; bootPC=0x100; stream words 0xA0,0xA1,0xA2 with last on the third.
  - Required: proc_RESET high throughout HOLD; writes land at 0x100, 0x104, 0x108; word_count=3; proc_RESET falls exactly SETTLE_CYCLES after the last write; startPC=0x100; booted=1.
- Backpressure and gaps: load_valid toggled 1,0,0,1,1 -> exactly 3 writes; imem_we never high on a gap cycle.
- Overflow: MAX_WORDS=2, offer 3 words with no last -> 2 writes; error=1; proc_RESET stays 1; restart -> HOLD with error=0, then a clean reboot.
- Halt/restart:
  - In RUN, assert halt -> next cycle proc_RESET=1 and booted=0.
  - Change bootPC to 0x200 and pulse restart -> after HOLD, startPC=0x200.
- Async reset mid-LOAD: assert RESET between edges after 1 write -> all outputs at reset values immediately; no further imem_we.
- BOOT_CHECKSUM_EN:
  - Stream 1,2,3 then trailer 6 -> RUN; 3 writes; trailer not written.
  - Repeat with trailer 7 -> ERROR, error=1.
